// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Turns the synchronised system reset into an ordered release: memory and
//   peripherals leave reset first, and the CPU core follows once memory
//   reports ready plus a guard gap. A software re-reset request restarts the
//   whole sequence from RUN. A memory-ready timeout parks the block in FAULT
//   until the next rst.
//
//   Optional watchdog: define RESET_SEQ_WDOG_EN. In RUN, WDOG_CYCLES cycles
//   without a wdog_kick restart the sequence and set the sticky wdog_cause.
//   In the default build wdog_kick is ignored and wdog_cause is tied 0.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset (highest priority)
//   mem_ready   in   memory/peripheral init done, level
//   sw_rst_req  in   one-cycle re-sequence request, honoured only in RUN
//   wdog_kick   in   watchdog kick pulse
//   mem_rst     out  active-high reset to memory/peripherals
//   core_rst    out  active-high reset to CPU core
//   running     out  1 only in RUN
//   fault       out  1 only in FAULT
//   phase       out  ASSERT=0, WAIT_MEM=1, GAP=2, RUN=3, FAULT=4
//   wdog_cause  out  sticky: last re-sequence was caused by the watchdog
module reset_sequencer #(
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int WDOG_CYCLES    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_ready,
  input  logic       sw_rst_req,
  input  logic       wdog_kick,
  output logic       mem_rst,
  output logic       core_rst,
  output logic       running,
  output logic       fault,
  output logic [2:0] phase,
  output logic       wdog_cause
);

  localparam int MAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_B = (TIMEOUT_CYCLES > WDOG_CYCLES) ? TIMEOUT_CYCLES : WDOG_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_ASSERT   = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_GAP      = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_rst_q, mem_rst_d;
  logic          core_rst_q, core_rst_d;
  logic          running_q, running_d;
  logic          fault_q, fault_d;
  logic [2:0]    phase_q, phase_d;

`ifdef RESET_SEQ_WDOG_EN
  localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYCLES - 1);
  logic wdog_cause_q, wdog_cause_d;
`else
  logic unused_wdog_kick;
  assign unused_wdog_kick = wdog_kick;
`endif

  // Next state. The shared counter restarts at 0 on every state change;
  // in RUN it doubles as the watchdog counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef RESET_SEQ_WDOG_EN
    wdog_cause_d = wdog_cause_q;
`endif
    unique case (state_q)
      ST_ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_MEM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_MEM: begin
        // Ready on the last allowed cycle beats the timeout.
        if (mem_ready) begin
          state_d = (GAP_CYCLES == 0) ? ST_RUN : ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        // Priority: software request, then kick, then watchdog expiry.
        if (sw_rst_req) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
`ifdef RESET_SEQ_WDOG_EN
          wdog_cause_d = 1'b0;
        end else if (wdog_kick) begin
          cnt_d = '0;
        end else if (cnt_q == WDOG_LAST) begin
          state_d      = ST_ASSERT;
          cnt_d        = '0;
          wdog_cause_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
`endif
        end
      end
      ST_FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered,
  // aligned with the state they describe.
  always_comb begin
    mem_rst_d  = (state_d == ST_ASSERT) || (state_d == ST_FAULT);
    core_rst_d = (state_d != ST_RUN);
    running_d  = (state_d == ST_RUN);
    fault_d    = (state_d == ST_FAULT);
    phase_d    = state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      mem_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      fault_q    <= 1'b0;
      phase_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_rst_q  <= mem_rst_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
      fault_q    <= fault_d;
      phase_q    <= phase_d;
    end
  end

`ifdef RESET_SEQ_WDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cause_q <= 1'b0;
    end else begin
      wdog_cause_q <= wdog_cause_d;
    end
  end
  assign wdog_cause = wdog_cause_q;
`else
  assign wdog_cause = 1'b0;
`endif

  assign mem_rst  = mem_rst_q;
  assign core_rst = core_rst_q;
  assign running  = running_q;
  assign fault    = fault_q;
  assign phase    = phase_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int TMO  = 64;
  localparam int WDOG = 8;
`ifdef RESET_SEQ_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  // {mem_rst, core_rst, running, fault, phase[2:0], wdog_cause}
  localparam logic [7:0] O_A  = 8'b1100_0000;
  localparam logic [7:0] O_W  = 8'b0100_0010;
  localparam logic [7:0] O_G  = 8'b0100_0100;
  localparam logic [7:0] O_R  = 8'b0010_0110;
  localparam logic [7:0] O_F  = 8'b1101_1000;

  logic       clk = 1'b0;
  logic       rst, mem_ready, sw_rst_req, wdog_kick;
  logic       mem_rst, core_rst, running, fault, wdog_cause;
  logic [2:0] phase;
  logic [7:0] dut_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .HOLD_CYCLES   (HOLD),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO),
    .WDOG_CYCLES   (WDOG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ready (mem_ready),
    .sw_rst_req(sw_rst_req),
    .wdog_kick (wdog_kick),
    .mem_rst   (mem_rst),
    .core_rst  (core_rst),
    .running   (running),
    .fault     (fault),
    .phase     (phase),
    .wdog_cause(wdog_cause)
  );

  assign dut_out = {mem_rst, core_rst, running, fault, phase, wdog_cause};

  // Reference: phase number plus how many cycles have elapsed in it.
  int m_phase = 0;
  int m_age   = 0;
  bit m_wc    = 1'b0;

  function automatic void model_edge(logic r, logic mr, logic sw, logic k);
    if (r) begin
      m_phase = 0; m_age = 0; m_wc = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_age++;
          if (m_age == HOLD) begin m_phase = 1; m_age = 0; end
        end
        1: begin
          m_age++;
          if (mr) begin m_phase = (GAP == 0) ? 3 : 2; m_age = 0; end
          else if (m_age == TMO) begin m_phase = 4; m_age = 0; end
        end
        2: begin
          m_age++;
          if (m_age == GAP) begin m_phase = 3; m_age = 0; end
        end
        3: begin
          if (sw) begin
            m_phase = 0; m_age = 0; m_wc = 1'b0;
          end else if (WD_EN) begin
            if (k) m_age = 0;
            else begin
              m_age++;
              if (m_age == WDOG) begin m_phase = 0; m_age = 0; m_wc = 1'b1; end
            end
          end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [7:0] model_out();
    logic [2:0] p;
    p = 3'(m_phase);
    return {(m_phase == 0) || (m_phase == 4), m_phase != 3, m_phase == 3,
            m_phase == 4, p, m_wc};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic mr, input logic sw, input logic k);
    rst = r; mem_ready = mr; sw_rst_req = sw; wdog_kick = k;
    @(posedge clk);
    model_edge(r, mr, sw, k);
    #1;
    check("model", dut_out, model_out());
  endtask

  typedef struct {
    logic       r;
    logic       mr;
    logic       sw;
    logic       k;
    int         n;
    logic [7:0] exp;
    string      name;
  } vec_t;

  function automatic vec_t mk(logic r, logic mr, logic sw, logic k, int n,
                              logic [7:0] exp, string name);
    vec_t v;
    v.r = r; v.mr = mr; v.sw = sw; v.k = k; v.n = n; v.exp = exp; v.name = name;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    logic mr_lvl;

    rst = 1'b1; mem_ready = 1'b0; sw_rst_req = 1'b0; wdog_kick = 1'b0;

    // Power-up, mem_ready high throughout
    vt.push_back(mk(1, 1, 0, 1, 3,  O_A, "por_hold"));
    vt.push_back(mk(0, 1, 0, 1, 15, O_A, "assert_15"));
    vt.push_back(mk(0, 1, 0, 1, 1,  O_W, "mem_release_16"));
    vt.push_back(mk(0, 1, 0, 1, 1,  O_G, "gap_entry"));
    vt.push_back(mk(0, 1, 0, 1, 3,  O_G, "gap_hold"));
    vt.push_back(mk(0, 1, 0, 1, 1,  O_R, "core_release"));
    vt.push_back(mk(0, 1, 0, 1, 5,  O_R, "run_steady"));
    // Software re-reset repeats the same timing
    vt.push_back(mk(0, 1, 1, 1, 1,  O_A, "sw_rst"));
    vt.push_back(mk(0, 1, 0, 1, 15, O_A, "sw_assert_15"));
    vt.push_back(mk(0, 1, 0, 1, 1,  O_W, "sw_mem_release"));
    vt.push_back(mk(0, 1, 0, 1, 1,  O_G, "sw_gap"));
    vt.push_back(mk(0, 1, 0, 1, 3,  O_G, "sw_gap_hold"));
    vt.push_back(mk(0, 1, 0, 1, 1,  O_R, "sw_run"));
    // Slow memory: ready sampled on the 30th WAIT_MEM cycle
    vt.push_back(mk(0, 0, 1, 1, 1,  O_A, "slow_sw"));
    vt.push_back(mk(0, 0, 0, 1, 16, O_W, "slow_wait"));
    vt.push_back(mk(0, 0, 0, 1, 29, O_W, "slow_wait29"));
    vt.push_back(mk(0, 1, 0, 1, 1,  O_G, "slow_ready"));
    vt.push_back(mk(0, 0, 0, 1, 3,  O_G, "gap_ignores_drop"));
    vt.push_back(mk(0, 0, 0, 1, 1,  O_R, "slow_run"));
    // Timeout into FAULT; sw ignored; rst recovers
    vt.push_back(mk(0, 0, 1, 1, 1,  O_A, "to_sw"));
    vt.push_back(mk(0, 0, 0, 1, 16, O_W, "to_wait"));
    vt.push_back(mk(0, 0, 0, 1, 63, O_W, "to_wait63"));
    vt.push_back(mk(0, 0, 0, 1, 1,  O_F, "timeout_64"));
    vt.push_back(mk(0, 0, 1, 1, 1,  O_F, "fault_ignores_sw"));
    vt.push_back(mk(0, 1, 0, 1, 3,  O_F, "fault_sticky"));
    vt.push_back(mk(1, 0, 0, 1, 1,  O_A, "fault_rst"));
    // Ready on the last allowed cycle wins over timeout
    vt.push_back(mk(0, 0, 0, 1, 16, O_W, "lc_wait"));
    vt.push_back(mk(0, 0, 0, 1, 63, O_W, "lc_wait63"));
    vt.push_back(mk(0, 1, 0, 1, 1,  O_G, "ready_last_cycle"));
    vt.push_back(mk(0, 1, 0, 1, 4,  O_R, "lc_run"));
    // sw outside RUN ignored, then rst during GAP
    vt.push_back(mk(0, 1, 1, 1, 1,  O_A, "mg_sw"));
    vt.push_back(mk(0, 1, 1, 1, 16, O_W, "sw_ignored_assert"));
    vt.push_back(mk(0, 1, 1, 1, 1,  O_G, "sw_ignored_wait"));
    vt.push_back(mk(0, 1, 1, 1, 1,  O_G, "sw_ignored_gap"));
    vt.push_back(mk(1, 1, 0, 1, 1,  O_A, "rst_in_gap"));
    vt.push_back(mk(0, 1, 0, 1, 15, O_A, "gap_rst_assert15"));
    vt.push_back(mk(0, 0, 0, 1, 1,  O_W, "gap_rst_wait"));
    // rst on WAIT_MEM cycle 63, then a full fresh timeout
    vt.push_back(mk(0, 0, 0, 1, 62, O_W, "wait62"));
    vt.push_back(mk(1, 0, 0, 1, 1,  O_A, "rst_wait63"));
    vt.push_back(mk(0, 0, 0, 1, 16, O_W, "w_restart"));
    vt.push_back(mk(0, 0, 0, 1, 63, O_W, "w_restart63"));
    vt.push_back(mk(0, 0, 0, 1, 1,  O_F, "w_restart_timeout"));
    vt.push_back(mk(1, 1, 0, 1, 1,  O_A, "final_rst"));

    foreach (vt[i]) begin
      for (int c = 0; c < vt[i].n; c++) step(vt[i].r, vt[i].mr, vt[i].sw, vt[i].k);
      check(vt[i].name, dut_out, vt[i].exp);
    end

    // Bring to RUN for the watchdog / kick corner cases
    for (int c = 0; c < 21; c++) step(0, 1, 0, 1);
    check("run_again", dut_out, O_R);

`ifdef RESET_SEQ_WDOG_EN
    for (int c = 0; c < 40; c++) step(0, 1, 0, (c % 5) == 4);
    check("wd_kicked_run", dut_out, O_R);
    step(0, 1, 0, 1);
    for (int c = 0; c < 7; c++) step(0, 1, 0, 0);
    check("wd_7_no_kick", dut_out, O_R);
    step(0, 1, 0, 0);
    check("wd_expire", dut_out, O_A | 8'b0000_0001);
    for (int c = 0; c < 21; c++) step(0, 1, 0, 1);
    check("wd_cause_sticky", dut_out, O_R | 8'b0000_0001);
    for (int c = 0; c < 7; c++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    check("wd_kick_wins", dut_out, O_R | 8'b0000_0001);
    for (int c = 0; c < 7; c++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    check("sw_beats_expiry", dut_out, O_A);
`else
    for (int c = 0; c < 20; c++) step(0, 1, 0, 0);
    check("kick_ignored", dut_out, O_R);
`endif

    // Randomised stimulus against the reference
    mr_lvl = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) mr_lvl = ~mr_lvl;
      step($urandom_range(0, 199) == 0, mr_lvl,
           $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
